// File: rtl/imem_load_ctrl.sv
// Instruction memory owner: serves 1-cycle registered core fetches in IDLE and
// hands the array to a burst loader (with core stall) during LOAD/DONE.
module imem_load_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   fetch_pc,
    output logic [31:0]   fetch_instr,
    output logic          fetch_valid,
    output logic          core_stall,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW:0]   ld_count,
    input  logic [31:0]   ld_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          ld_done,
    output logic          ld_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] addr;
    logic [AW:0]   rem;
    logic          count_legal;
    logic          start_ok;
    logic          wr_en;
    logic          pc_in_range;
    logic [AW-1:0] rd_idx;
    logic          unused_pc_lsbs;

    assign count_legal    = (ld_count != '0) && (ld_count <= (AW+1)'(DEPTH));
    assign start_ok       = ld_start && count_legal;
    assign pc_in_range    = (fetch_pc[31:AW+2] == '0);
    assign rd_idx         = fetch_pc[AW+1:2];
    assign unused_pc_lsbs = ^fetch_pc[1:0];
    assign wr_en          = ld_ready && ld_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = LOAD;
            LOAD:    if (ld_valid && rem == (AW+1)'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded straight from the state register, so these change only on clock edges.
    always_comb begin
        core_stall = 1'b0;
        ld_busy    = 1'b0;
        ld_ready   = 1'b0;
        ld_done    = 1'b0;
        case (state)
            LOAD: begin
                core_stall = 1'b1;
                ld_busy    = 1'b1;
                ld_ready   = 1'b1;
            end
            DONE: begin
                core_stall = 1'b1;
                ld_done    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            rem         <= '0;
            ld_err      <= 1'b0;
            fetch_instr <= '0;
            fetch_valid <= 1'b0;
        end else begin
            ld_err <= (state == IDLE) && ld_start && !count_legal;
            if (state == IDLE && start_ok) begin
                addr <= ld_base;
                rem  <= ld_count;
            end else if (wr_en) begin
                addr <= addr + 1'b1;
                rem  <= rem - 1'b1;
            end
            // The accepting IDLE cycle already belongs to the load: instr holds, valid drops.
            if (state == IDLE && !start_ok) begin
                fetch_valid <= 1'b1;
                fetch_instr <= pc_in_range ? mem[rd_idx] : '0;
            end else begin
                fetch_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[addr] <= ld_data;
    end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Controller and owner of the single-port instruction memory (DEPTH x 32). It arbitrates between the core fetch path and a program-loader port. While a load runs, the loader owns the array and the core is stalled; otherwise the core fetches word-aligned instructions with 1-cycle registered read latency. The block sits between the PC register / instruction decode and a host/debug loader.

Parameters:
DEPTH, 16, number of 32-bit instruction words (power of 2)
AW, 4, word address width, log2(DEPTH)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
fetch_pc  in  32  byte address from core PC
fetch_instr  out  32  registered instruction word
fetch_valid  out  1  fetch_instr is valid for the PC presented last cycle
core_stall  out  1  core must hold its PC
ld_start  in  1  request a load burst (sampled in IDLE only)
ld_base  in  AW  first word address of burst (sampled with ld_start)
ld_count  in  AW+1  number of words in burst (sampled with ld_start)
ld_data  in  32  word to write
ld_valid  in  1  ld_data valid
ld_ready  out  1  controller accepts ld_data this cycle
ld_busy  out  1  burst in progress
ld_done  out  1  1-cycle pulse, burst complete
ld_err  out  1  1-cycle pulse, illegal ld_count rejected

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; fetch_instr=0, fetch_valid=0, core_stall=0, ld_ready=0, ld_busy=0, ld_done=0, ld_err=0. Memory array is not cleared by rst (contents hold, sim-initialised to 0).
- States: IDLE, LOAD, DONE.
- IDLE:
  - Every cycle read word fetch_pc[AW+1:2]; next edge registers it into fetch_instr and sets fetch_valid=1.
  - If fetch_pc[31:AW+2] != 0, fetch_instr gets 32'h0000_0000 (NOP), fetch_valid=1.
  - fetch_pc[1:0] is ignored.
  - On ld_start=1 with 1 <= ld_count <= DEPTH: latch addr=ld_base and rem=ld_count, then go to LOAD.
  - On ld_start=1 with ld_count=0 or ld_count>DEPTH: pulse ld_err for 1 cycle and stay in IDLE. Fetch is unaffected.
- LOAD:
  - core_stall=1, ld_busy=1, ld_ready=1, fetch_valid=0, fetch_instr holds its last value.
  - Handshake: a word is written only on a cycle with ld_valid=1 and ld_ready=1. It writes mem[addr] <= ld_data, then addr <= addr+1 mod DEPTH (wraps DEPTH-1 -> 0) and rem <= rem-1.
  - ld_valid=0 cycles are stalls; nothing changes.
  - The write that takes rem from 1 to 0 moves the state to DONE.
  - ld_start is ignored in LOAD.
- DONE (exactly 1 cycle):
  - ld_done=1, ld_ready=0, ld_busy=0, core_stall=1, fetch_valid=0; then go to IDLE.
- Stall timing: core_stall is registered. It rises the cycle after ld_start is accepted and falls the cycle after DONE.
- Fetch resumes on the first IDLE cycle after DONE. fetch_valid rises one cycle later with post-load contents.
- Same-cycle read/write cannot occur: fetch reads happen only in IDLE, writes only in LOAD.
- Reset mid-LOAD: the next state is IDLE. Words already written remain in memory, no ld_done pulse, core_stall=0.
- Latency summary:
  - fetch: 1 cycle.
  - burst of N words with no gaps: N cycles in LOAD + 1 cycle in DONE.
- Implementation target: ~150-250 lines of RTL.

Test Plan:
- Reset then fetch: preload mem[0..2]=00221820, AC010000, 8C240000; drive fetch_pc=0,4,8 on successive cycles -> fetch_instr=00221820, AC010000, 8C240000 one cycle later each, fetch_valid=1, core_stall=0.
- Load with gaps: ld_start, ld_base=2, ld_count=3; ld_valid pattern 1,0,1,1 with data A,B,C -> mem[2..4]=A,B,C; ld_ready=1 for 4 cycles; ld_done pulses once; core_stall=1 throughout LOAD and DONE; fetch_pc=8 afterwards -> fetch_instr=A.
- Wrap-around: ld_base=14, ld_count=4, data W0..W3 -> mem[14]=W0, mem[15]=W1, mem[0]=W2, mem[1]=W3; mem[2] unchanged.
- Illegal count: ld_count=0, then ld_count=17 -> ld_err 1-cycle pulse each, state stays IDLE, core_stall=0, memory unchanged.
- Reset mid-load: ld_count=4, assert rst after 2 accepted words -> mem holds the 2 written words, all outputs at reset values, no ld_done; a new ld_start afterwards is accepted normally.
- Out-of-range fetch and ignored start: fetch_pc=32'h0000_0040 -> fetch_instr=0, fetch_valid=1; ld_start pulsed during LOAD -> no change to addr/rem, the original burst completes.
